// File: rtl/menu_audio_pkg.sv
// Shared audio constants and types for the menu core's I2S DAC and ADC paths.
package menu_audio_pkg;

    localparam int unsigned AUDIO_W         = 16;
    // clk_sys cycles per BCK half-period for the 12 MHz system clock
    localparam int unsigned CLK_DIV_DEFAULT = 4;

    typedef struct packed {
        logic [AUDIO_W-1:0] left;
        logic [AUDIO_W-1:0] right;
    } audio_frame_t;

endpackage

// File: rtl/menu_i2s_tx_if.sv
// Stereo PCM frame handshake between the audio source and the I2S serialiser.
interface menu_i2s_tx_if #(
    parameter int unsigned W = menu_audio_pkg::AUDIO_W
) ();

    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_left;
    logic [W-1:0] s_right;

    modport master (output s_valid, output s_left, output s_right, input  s_ready);
    modport slave  (input  s_valid, input  s_left, input  s_right, output s_ready);

endinterface

// File: rtl/i2s_clkgen.sv
// Bit-clock divider: registered BCK plus a same-cycle strobe marking each BCK falling edge.
module i2s_clkgen
    import menu_audio_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    output logic bck_o,
    output logic fall_c_o
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q;
    logic             bck_q;
    logic             tc_c;

    assign tc_c = (div_q == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i || !en_i) begin
            div_q <= '0;
            bck_q <= 1'b0;
        end else if (tc_c) begin
            div_q <= '0;
            bck_q <= ~bck_q;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Fall strobe masked while reset or en=0 clears the divider
    assign fall_c_o = tc_c & bck_q & en_i & ~reset_i;
    assign bck_o    = bck_q;

endmodule

// File: rtl/menu_i2s_tx.sv
// Philips-format I2S transmitter: one-deep frame holding register, bit index counter and serial output.
module menu_i2s_tx
    import menu_audio_pkg::*;
#(
    parameter int unsigned W       = AUDIO_W,
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic           clk_sys,
    input  logic           reset,
    input  logic           en,
    menu_i2s_tx_if.slave   s,
    output logic           i2s_bck,
    output logic           i2s_lrck,
    output logic           i2s_data,
    output logic           underrun
);

    localparam int unsigned FRAME_W = 2 * W;
    localparam int unsigned KW      = $clog2(FRAME_W);

    logic               fall_c;
    logic               load_now_c;
    logic               accept_c;
    logic [KW-1:0]      k_q;
    logic [KW-1:0]      k_d;
    logic [KW-1:0]      sel_c;
    logic [FRAME_W-1:0] frame_q;
    logic [FRAME_W-1:0] hold_q;
    logic               hold_full_q;
    logic               lrck_q;
    logic               data_q;
    logic               underrun_q;

    i2s_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk_i    (clk_sys),
        .reset_i  (reset),
        .en_i     (en),
        .bck_o    (i2s_bck),
        .fall_c_o (fall_c)
    );

    // k_q holds the index that the next fall event will take
    assign load_now_c = fall_c & (k_q == '0);
    assign s.s_ready  = ~hold_full_q | load_now_c;
    assign accept_c   = s.s_valid & s.s_ready;
    assign k_d        = (k_q == KW'(FRAME_W - 1)) ? '0 : k_q + KW'(1);
    // Index 0 emits the previous frame's last bit: that is the one-BCK MSB delay
    assign sel_c      = (k_q == '0) ? '0 : KW'(FRAME_W) - k_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            k_q         <= '0;
            frame_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            lrck_q      <= 1'b0;
            data_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else if (!en) begin
            k_q         <= '0;
            hold_full_q <= 1'b0;
            lrck_q      <= 1'b0;
            data_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            underrun_q <= load_now_c & ~hold_full_q;
            if (fall_c) begin
                k_q    <= k_d;
                lrck_q <= (k_q >= KW'(W));
                data_q <= frame_q[sel_c];
            end
            if (load_now_c && hold_full_q) begin
                frame_q <= hold_q;
            end
            if (accept_c) begin
                hold_q      <= {s.s_left, s.s_right};
                hold_full_q <= 1'b1;
            end else if (load_now_c) begin
                hold_full_q <= 1'b0;
            end
        end
    end

    assign i2s_lrck = lrck_q;
    assign i2s_data = data_q;
    assign underrun = underrun_q;

endmodule
